// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM encodings, opcodes and
// the result pattern returned for illegal opcodes.
package alu_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t EXEC = 2'd1;
    localparam arb_state_t RESP = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd4;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU with zero-extended operands and a 32-bit result.
// Opcodes above OP_MAX return ERR_PATTERN.
module alu
    import alu_arb_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  op,
    output logic [31:0] y
);

    logic [31:0] a_ext;
    logic [31:0] b_ext;

    assign a_ext = {16'h0000, a};
    assign b_ext = {16'h0000, b};

    always_comb begin
        y = ERR_PATTERN;
        case (op)
            OP_ADD:  y = a_ext + b_ext;
            OP_SUB:  y = a_ext - b_ext;
            OP_AND:  y = a_ext & b_ext;
            OP_OR:   y = a_ext | b_ext;
            OP_XOR:  y = a_ext ^ b_ext;
            default: y = ERR_PATTERN;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          k;
    logic [IW-1:0] kk;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            k  = (int'(ptr) + i) % N;
            kk = IW'(k);
            if (en && !any && req[kk]) begin
                any       = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a single
// response channel. Define ALU_ARBITER_STATS_EN to build op/err counters.
//
// state | meaning
// IDLE  | no operation in flight; grant any valid request
// EXEC  | ALU evaluating latched operands; result registered this cycle
// RESP  | response held until resp_ready; may grant next request same cycle
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [31:0]           op_count,
    output logic [15:0]           err_count
);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [15:0]     lat_a;
    logic [15:0]     lat_b;
    logic [2:0]      lat_op;
    logic [ID_W-1:0] lat_id;

    logic [15:0]     a_arr  [NUM_REQ];
    logic [15:0]     b_arr  [NUM_REQ];
    logic [2:0]      op_arr [NUM_REQ];

    logic               grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [31:0]        alu_y;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = req_a[16*i +: 16];
            b_arr[i]  = req_b[16*i +: 16];
            op_arr[i] = req_op[3*i +: 3];
        end
    end

    // A grant in RESP is only legal on the cycle the held response retires.
    assign grant_en  = (state == IDLE) || ((state == RESP) && resp_ready);
    assign req_ready = gnt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (grant_en),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    alu u_alu (
        .a  (lat_a),
        .b  (lat_b),
        .op (lat_op),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (gnt_any) begin
                lat_a  <= a_arr[gnt_idx];
                lat_b  <= b_arr[gnt_idx];
                lat_op <= op_arr[gnt_idx];
                lat_id <= gnt_idx;
                rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gnt_any) state <= EXEC;
                end
                EXEC: begin
                    resp_data  <= alu_y;
                    resp_err   <= op_illegal(lat_op);
                    resp_id    <= lat_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= gnt_any ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [31:0] op_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (resp_valid && resp_ready) begin
            op_cnt <= op_cnt + 32'd1;
            if (resp_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign op_count  = op_cnt;
    assign err_count = err_cnt;
`else
    assign op_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the existing combinational ALU between NUM_REQ requesters.
- Each requester issues an operation over a valid/ready request channel.
- The block picks one requester by round-robin, latches its operands, runs the ALU, and returns the result with a requester ID on one shared valid/ready response channel.
- It sits between the instruction/issue logic and the ALU, so the ALU needs no knowledge of who is using it.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of the requester ID (derived; not overridden).

Ports:
- clk  input  1  — the single clock.
- rst_n  input  1  — asynchronous, active-low reset.
- req_valid  input  NUM_REQ  — per-requester request valid.
- req_ready  output  NUM_REQ  — per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*16  — operand A; requester i uses bits [16*i+15:16*i].
- req_b  input  NUM_REQ*16  — operand B; same packing as req_a.
- req_op  input  NUM_REQ*3  — ALU opcode; requester i uses bits [3*i+2:3*i].
- resp_valid  output  1  — response valid.
- resp_ready  input  1  — response accept.
- resp_id  output  ID_W  — index of the requester that owns the response.
- resp_data  output  32  — ALU result.
- resp_err  output  1  — opcode was illegal (greater than 4).
- op_count  output  32  — completed operations (optional feature).
- err_count  output  16  — completed operations flagged resp_err (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - Latched operands cleared; counters cleared.
  - Any in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid, grant the winner (req_ready[w]=1 combinationally), latch a/b/op/id, go to EXEC. Otherwise stay in IDLE.
  - EXEC: ALU is driven from the latched operands. Register resp_data=ALU out, resp_err=(op>4), resp_id=latched id. Set resp_valid=1 and go to RESP.
  - RESP: hold resp_valid and all response fields stable until resp_ready.
    - On resp_ready with a pending request: same-cycle grant, go to EXEC.
    - On resp_ready with no pending request: go to IDLE.
- req_ready is asserted only when state==IDLE, or state==RESP && resp_ready. Never more than one bit is set. It depends on req_valid and resp_ready combinationally.
- Latency: accept in cycle N, resp_valid in cycle N+2. Sustained throughput is one operation per 2 cycles while resp_ready is held high.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - After granting requester w, rr_ptr = (w+1) mod NUM_REQ. At w=NUM_REQ-1, rr_ptr wraps to 0.
  - rr_ptr is unchanged when nothing is granted.
- Illegal opcode (5..7):
  - Not rejected; executes normally.
  - resp_data=32'hDEAD_BEEF (passed through from the ALU), resp_err=1.
- Arithmetic: 16-bit operands are zero-extended by the ALU. The subtract result is the ALU's 32-bit result; the arbiter does not alter it.
- A requester must hold req_valid and its fields stable until granted. The arbiter never drops a held request.
- Simultaneous events: a new request arriving while resp_valid is high and resp_ready is low waits; no grant occurs.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - op_count increments by 1 on every response handshake (resp_valid && resp_ready), wrapping 2^32-1 → 0.
  - err_count increments on handshakes with resp_err=1, saturating at 16'hFFFF.
  - Both counters cleared by reset.
- Not defined: the counter logic is compiled out; op_count and err_count are tied to 0. Ports remain for a stable interface.

Decomposition:
- Package alu_arb_pkg:
  - State enum: IDLE, EXEC, RESP.
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4; OP_MAX=4.
  - ERR_PATTERN=32'hDEAD_BEEF.
- Sub-module rr_arbiter (parameter N): inputs req vector, ptr, enable; outputs one-hot grant and encoded index. Pure combinational; rr_ptr stays in the parent.
- The ALU is instantiated inside alu_arbiter.

Test Plan:
- Single request: req0 a=5, b=3, op=0 → accepted cycle N; cycle N+2 resp_valid, resp_id=0, resp_data=8, resp_err=0.
- Subtract wrap: a=3, b=5, op=1 → resp_data=32'hFFFF_FFFE.
- Fairness: all 4 requesters hold req_valid, resp_ready=1 → grant order 0,1,2,3,0, one response every 2 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → response fields stable, no req_ready asserted. Raising resp_ready grants the next pending request in that same cycle.
- Illegal opcode: op=7, a=1, b=1 → resp_data=32'hDEAD_BEEF, resp_err=1. With ALU_ARBITER_STATS_EN defined: err_count=1, op_count=1.
- Reset mid-operation: assert rst_n=0 while in EXEC → resp_valid=0 immediately, no response after release, next grant starts at requester 0.
